vpu_reduce16: RTL and testbench
===============================

# vpu_reduce16

Collector stage downstream of the 16-bit VPU integer ALU lane. It consumes one ALU result per cycle (result word plus `gt`/`eq` compare flags) for a vector of up to 16 elements. It builds per-element compare masks and an optional scalar reduction (sum, signed max, signed min, or last element), then presents the packed result to the writeback/scalar side over a valid/ready handshake.

## Interface
- `VLEN_MAX`, 16: maximum elements per vector op; also the width of the mask outputs.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a vector op; sampled only in IDLE.
- `vl`  in  5: vector length, latched on accepted `start`. Values above 16 clamp to 16; 0 is legal.
- `red_op`  in  2: reduction, latched on `start`. 00 = last element, 01 = sum, 10 = signed max, 11 = signed min.
- `abort`  in  1: synchronous flush to IDLE; priority over everything except reset.
- `elem_valid`  in  1: ALU result valid.
- `elem_ready`  out  1: collector can accept an element.
- `elem_data`  in  16: ALU result word.
- `elem_gt`  in  1: ALU greater-than flag for this element.
- `elem_eq`  in  1: ALU equal flag for this element.
- `res_valid`  out  1: packed result valid.
- `res_ready`  in  1: consumer accepts the result.
- `res_data`  out  16: reduction result.
- `res_gt_mask`  out  16: bit i = `elem_gt` of element i.
- `res_eq_mask`  out  16: bit i = `elem_eq` of element i.
- `res_count`  out  5: number of elements accepted.
- `busy`  out  1: state is not IDLE.

## Operation
- States are IDLE, ACCUM and DONE. All outputs reset to 0 and state resets to IDLE.
- **IDLE:**
  - On `start`: latch the clamped `vl` and `red_op`, clear both masks and the count, and load the accumulator with the identity value. Identities: sum 0x0000, max 0x8000, min 0x7FFF, last 0x0000.
  - Next state is ACCUM if the clamped vl is nonzero, otherwise DONE.
- **ACCUM:**
  - `elem_ready` = 1. A handshake is `elem_valid & elem_ready`.
  - Each handshake sets mask bit [count] from `elem_gt`/`elem_eq` and increments count.
  - Accumulator update per handshake:
    - sum: acc + data, modulo 2^16, no overflow flag.
    - max: data replaces acc if signed data > acc.
    - min: data replaces acc if signed data < acc.
    - last: acc = data.
    - For max/min ties, acc is kept.
  - On the handshake where count+1 == vl, go to DONE.
- **DONE:**
  - `res_valid` = 1. `res_data`, the masks and `res_count` stay stable until `res_valid & res_ready`, then go to IDLE.
  - Outputs keep their last values in IDLE and are cleared only by the next accepted `start`.
- `elem_ready` = 0 in IDLE and DONE. Elements offered then are not consumed; the upstream stage must hold them.
- `start` in ACCUM or DONE is ignored, with no queuing.
- `abort`: next state IDLE; `res_valid` and `elem_ready` drop the following cycle. The masks, count and accumulator keep partial values, and `res_valid` is never raised for the aborted op.
- Mask bits at or above vl remain 0.

## Timing
- Throughput: 1 element per cycle in ACCUM.
- `start` at edge t, nonzero vl: `elem_ready` high from t+1.
- Last element handshake at edge t: `res_valid` high from t+1, and `res_data` already reflects that element.
- vl = 0: `start` at edge t, `res_valid` at t+1 with identity data, zero masks, count 0.
- Result handshake at edge t: IDLE at t+1. The earliest new `start` is accepted at edge t+1, a one-cycle bubble between ops.
- `res_ready` held high before `res_valid`: handshake completes on the first DONE cycle.
- `abort` and `start` in the same IDLE cycle: abort wins and `start` is dropped.
- Reset asserted mid-op: immediate IDLE with all outputs 0; no partial result is emitted after release.

## Test plan
- **Sum with wrap:** vl=4, red_op=01, data 0x7FFF, 0x0002, 0xFFFF, 0x0001, back-to-back → `res_valid` one cycle after the 4th element, `res_data`=0x8001, `res_count`=4.
- **Signed max and min:** vl=3, data 0xFFF0, 0x0005, 0x8000.
  - red_op=10 → 0x0005.
  - red_op=11 → 0x8000.
  - Per element, gt=1,0,1 and eq=0,1,0 → `res_gt_mask`=0x0005, `res_eq_mask`=0x0002.
- **Clamp and masks:** vl=20, all gt=1, red_op=00, last data 0xABCD → exactly 16 elements accepted, `res_gt_mask`=0xFFFF, `res_count`=16, `res_data`=0xABCD; `elem_ready` low after the 16th.
- **vl = 0:** red_op=11 → `res_valid` the cycle after `start`, `res_data`=0x7FFF, masks 0, count 0.
- **Backpressure and stray inputs:**
  - `res_ready` low for 5 cycles in DONE → outputs stable and `elem_ready` 0 throughout.
  - `start` pulsed in DONE → ignored.
  - After `res_ready`, IDLE, then a new `start` is accepted.
- **Abort and reset mid-op:**
  - vl=8, `abort` after 3 elements → IDLE next cycle, no `res_valid`, and a new op then completes correctly.
  - Repeat with `rst_n` low instead → all outputs 0 immediately.

Source files
------------

// File: rtl/vpu_reduce16.sv
// Collects one ALU lane result per cycle into per-element gt/eq masks and a scalar
// reduction (last/sum/signed max/signed min), then presents it over valid/ready.
module vpu_reduce16 #(
  parameter int unsigned VLEN_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4:0]          vl,
  input  logic [1:0]          red_op,
  input  logic                abort,
  input  logic                elem_valid,
  output logic                elem_ready,
  input  logic [15:0]         elem_data,
  input  logic                elem_gt,
  input  logic                elem_eq,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [15:0]         res_data,
  output logic [VLEN_MAX-1:0] res_gt_mask,
  output logic [VLEN_MAX-1:0] res_eq_mask,
  output logic [4:0]          res_count,
  output logic                busy
);

  localparam int unsigned IW   = $clog2(VLEN_MAX);
  localparam logic [4:0]  VMAX = 5'(VLEN_MAX);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          vl_q, vl_d;
  logic [1:0]          op_q, op_d;
  logic [15:0]         acc_q, acc_d;
  logic [VLEN_MAX-1:0] gt_q, gt_d;
  logic [VLEN_MAX-1:0] eq_q, eq_d;
  logic [4:0]          cnt_q, cnt_d;

  logic [4:0]  vl_clamped;
  logic [15:0] identity;

  assign vl_clamped = (vl > VMAX) ? VMAX : vl;

  always_comb begin
    identity = '0;
    unique case (red_op)
      2'b10:   identity = 16'h8000;
      2'b11:   identity = 16'h7FFF;
      default: identity = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    op_d    = op_q;
    acc_d   = acc_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    cnt_d   = cnt_q;
    // Abort only redirects the state; datapath keeps its partial contents.
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            vl_d    = vl_clamped;
            op_d    = red_op;
            acc_d   = identity;
            gt_d    = '0;
            eq_d    = '0;
            cnt_d   = '0;
            state_d = (vl_clamped != 5'd0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (elem_valid) begin
            gt_d[cnt_q[IW-1:0]] = elem_gt;
            eq_d[cnt_q[IW-1:0]] = elem_eq;
            cnt_d = cnt_q + 5'd1;
            unique case (op_q)
              2'b00: acc_d = elem_data;
              2'b01: acc_d = acc_q + elem_data;
              2'b10: if ($signed(elem_data) > $signed(acc_q)) acc_d = elem_data;
              2'b11: if ($signed(elem_data) < $signed(acc_q)) acc_d = elem_data;
              default: acc_d = acc_q;
            endcase
            if (cnt_q + 5'd1 == vl_q) state_d = DONE;
          end
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vl_q    <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vl_q    <= vl_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign elem_ready  = (state_q == ACCUM);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign res_data    = acc_q;
  assign res_gt_mask = gt_q;
  assign res_eq_mask = eq_q;
  assign res_count   = cnt_q;

endmodule

// File: tb/tb_vpu_reduce16.sv
// Directed bench for vpu_reduce16: a reference reduction model plus literal expectations.
module tb_vpu_reduce16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  vl;
  logic [1:0]  red_op;
  logic        abort;
  logic        elem_valid;
  logic        elem_ready;
  logic [15:0] elem_data;
  logic        elem_gt;
  logic        elem_eq;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [15:0] res_gt_mask;
  logic [15:0] res_eq_mask;
  logic [4:0]  res_count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] vd [16];
  logic        vg [16];
  logic        ve [16];

  logic [15:0] exp_data;
  logic [15:0] exp_gt;
  logic [15:0] exp_eq;
  logic [4:0]  exp_cnt;
  logic        allow_valid = 1'b0;

  vpu_reduce16 #(.VLEN_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vl(vl), .red_op(red_op),
    .abort(abort), .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_data(elem_data), .elem_gt(elem_gt), .elem_eq(elem_eq),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_gt_mask(res_gt_mask), .res_eq_mask(res_eq_mask),
    .res_count(res_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference reduction over the first n elements using signed integer arithmetic.
  function automatic logic [15:0] model_red(input logic [1:0] op, input int n);
    int acc;
    int sv;
    case (op)
      2'b10:   acc = -32768;
      2'b11:   acc = 32767;
      default: acc = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      sv = int'($signed(vd[i]));
      case (op)
        2'b00: acc = sv;
        2'b01: acc = acc + sv;
        2'b10: if (sv > acc) acc = sv;
        default: if (sv < acc) acc = sv;
      endcase
    end
    return 16'(acc);
  endfunction

  function automatic logic [15:0] model_mask(input bit use_eq, input int n);
    logic [15:0] m = '0;
    for (int i = 0; i < n; i++) m[i] = use_eq ? ve[i] : vg[i];
    return m;
  endfunction

  // Whenever a result is presented it must match the model of the current op.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      check("valid_gate", res_valid, allow_valid);
      check("res_data", res_data, exp_data);
      check("res_gt_mask", res_gt_mask, exp_gt);
      check("res_eq_mask", res_eq_mask, exp_eq);
      check("res_count", res_count, exp_cnt);
      check("ready_in_done", elem_ready, 1'b0);
    end
  end

  task automatic run_op(input logic [4:0] v, input logic [1:0] op, input int hold,
                        input bit pre_ready, input bit stray_start);
    int n;
    n = (v > 5'd16) ? 16 : int'(v);
    @(negedge clk);
    exp_data    = model_red(op, n);
    exp_gt      = model_mask(1'b0, n);
    exp_eq      = model_mask(1'b1, n);
    exp_cnt     = 5'(n);
    allow_valid = 1'b1;
    start  = 1'b1;
    vl     = v;
    red_op = op;
    res_ready = pre_ready;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", elem_ready, n != 0);
    for (int i = 0; i < n; i++) begin
      elem_valid = 1'b1;
      elem_data  = vd[i];
      elem_gt    = vg[i];
      elem_eq    = ve[i];
      check("ready_accum", elem_ready, 1'b1);
      @(negedge clk);
    end
    // Stray element offered while the result is pending must not be consumed.
    elem_valid = 1'b1;
    elem_data  = 16'hDEAD;
    elem_gt    = 1'b1;
    elem_eq    = 1'b1;
    check("valid_after_last", res_valid, 1'b1);
    check("ready_low_done", elem_ready, 1'b0);
    if (!pre_ready) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("hold_valid", res_valid, 1'b1);
        check("hold_ready", elem_ready, 1'b0);
        start = stray_start && (k == 1);
        vl    = 5'd2;
      end
      start     = 1'b0;
      res_ready = 1'b1;
    end
    @(negedge clk);
    res_ready  = 1'b0;
    elem_valid = 1'b0;
    check("idle_valid", res_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  task automatic partial_op(input bit use_reset);
    @(negedge clk);
    allow_valid = 1'b0;
    start  = 1'b1;
    vl     = 5'd8;
    red_op = 2'b01;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      elem_valid = 1'b1;
      elem_data  = vd[i];
      elem_gt    = vg[i];
      elem_eq    = ve[i];
      @(negedge clk);
    end
    elem_valid = 1'b0;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_ready", elem_ready, 1'b0);
      check("rst_valid", res_valid, 1'b0);
      check("rst_data", res_data, 16'h0000);
      check("rst_gt", res_gt_mask, 16'h0000);
      check("rst_eq", res_eq_mask, 16'h0000);
      check("rst_count", res_count, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_ready", elem_ready, 1'b0);
      check("abort_valid", res_valid, 1'b0);
      check("abort_count", res_count, 5'd3);
      check("abort_data", res_data, model_red(2'b01, 3));
    end
    repeat (3) begin
      @(negedge clk);
      check("post_flush_valid", res_valid, 1'b0);
      check("post_flush_busy", busy, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; vl = '0; red_op = '0; abort = 1'b0;
    elem_valid = 1'b0; elem_data = '0; elem_gt = 1'b0; elem_eq = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", res_valid, 1'b0);
    check("reset_ready", elem_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_data", res_data, 16'h0000);
    check("reset_count", res_count, 5'd0);
    rst_n = 1'b1;

    // Sum with wrap, with 5 cycles of backpressure and a stray start in DONE.
    vd[0] = 16'h7FFF; vd[1] = 16'h0002; vd[2] = 16'hFFFF; vd[3] = 16'h0001;
    for (int i = 0; i < 4; i++) begin vg[i] = 1'b0; ve[i] = 1'b0; end
    run_op(5'd4, 2'b01, 5, 1'b0, 1'b1);
    check("sum_lit", res_data, 16'h8001);
    check("sum_cnt_lit", res_count, 5'd4);

    // Signed max and min.
    vd[0] = 16'hFFF0; vd[1] = 16'h0005; vd[2] = 16'h8000;
    vg[0] = 1'b1; vg[1] = 1'b0; vg[2] = 1'b1;
    ve[0] = 1'b0; ve[1] = 1'b1; ve[2] = 1'b0;
    run_op(5'd3, 2'b10, 0, 1'b1, 1'b0);
    check("max_lit", res_data, 16'h0005);
    check("gt_mask_lit", res_gt_mask, 16'h0005);
    check("eq_mask_lit", res_eq_mask, 16'h0002);
    run_op(5'd3, 2'b11, 1, 1'b0, 1'b0);
    check("min_lit", res_data, 16'h8000);

    // vl above 16 clamps; last-element reduction.
    for (int i = 0; i < 16; i++) begin
      vd[i] = 16'(i * 16'h0111);
      vg[i] = 1'b1;
      ve[i] = i[0];
    end
    vd[15] = 16'hABCD;
    run_op(5'd20, 2'b00, 2, 1'b0, 1'b0);
    check("clamp_data_lit", res_data, 16'hABCD);
    check("clamp_gt_lit", res_gt_mask, 16'hFFFF);
    check("clamp_eq_lit", res_eq_mask, 16'hAAAA);
    check("clamp_cnt_lit", res_count, 5'd16);

    // vl = 0 produces the identity immediately.
    run_op(5'd0, 2'b11, 1, 1'b0, 1'b0);
    check("vl0_data_lit", res_data, 16'h7FFF);
    check("vl0_cnt_lit", res_count, 5'd0);
    check("vl0_gt_lit", res_gt_mask, 16'h0000);

    // Abort mid-op, then a full op.
    for (int i = 0; i < 8; i++) begin
      vd[i] = 16'(16'h0010 + i);
      vg[i] = i[1];
      ve[i] = ~i[0];
    end
    partial_op(1'b0);
    run_op(5'd8, 2'b01, 0, 1'b1, 1'b0);
    check("after_abort_lit", res_data, 16'h009C);

    // Abort beats start in the same IDLE cycle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; vl = 5'd3;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    check("abort_start_ready", elem_ready, 1'b0);

    // Reset mid-op, then a full op.
    partial_op(1'b1);
    run_op(5'd5, 2'b10, 1, 1'b0, 1'b0);
    check("after_reset_lit", res_data, 16'h0014);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
